// File: rtl/sc_backg_pkg.sv
// rtl/sc_backg_pkg.sv - shared defaults and channel state encoding for sc_backg_timer
package sc_backg_pkg;

    localparam int          DATAWIDTH_TIMER_DEF = 23;
    localparam int unsigned T0_LIMIT_DEF        = 32'd5000000;
    localparam int unsigned T1_LIMIT_DEF        = 32'd2500000;

    typedef enum logic {
        COUNTING = 1'b0,
        TERMINAL = 1'b1
    } chan_state_e;

endpackage

// File: rtl/sc_backg_timer_channel.sv
// rtl/sc_backg_timer_channel.sv - one strobe counter with terminal-count flag
//
// Ports:
//   clk       - system clock
//   rst       - synchronous reset, active-high (count 0, COUNTING, flag high)
//   clear_n   - synchronous clear, active-low, overrides the strobe
//   strobe_n  - increment strobe, active-low
//   limit     - period in strobes (count wraps at limit-1)
//   count     - current counter value
//   flag_n    - registered terminal-count flag, low while in TERMINAL
module sc_backg_timer_channel
    import sc_backg_pkg::*;
#(
    parameter int W = DATAWIDTH_TIMER_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_n,
    input  logic         strobe_n,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         flag_n
);

    logic [W-1:0] count_q, count_d;
    chan_state_e  state_q, state_d;
    logic         flag_n_q, flag_n_d;
    logic [W-1:0] limit_m1;

    assign limit_m1 = limit - W'(1);

    always_comb begin
        count_d = count_q;
        state_d = state_q;
        if (!clear_n) begin
            count_d = '0;
            state_d = COUNTING;
        end else if (!strobe_n) begin
            // >= keeps the counter bounded even if the limit ever shrinks
            // underneath a running count.
            if (count_q >= limit_m1) begin
                count_d = '0;
                state_d = TERMINAL;
            end else begin
                count_d = count_q + W'(1);
                state_d = COUNTING;
            end
        end
        flag_n_d = (state_d != TERMINAL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            state_q  <= COUNTING;
            flag_n_q <= 1'b1;
        end else begin
            count_q  <= count_d;
            state_q  <= state_d;
            flag_n_q <= flag_n_d;
        end
    end

    assign count  = count_q;
    assign flag_n = flag_n_q;

endmodule

// File: rtl/sc_backg_timer.sv
// rtl/sc_backg_timer.sv - two independent strobe-driven background timers
//
// Optional feature macro: SC_BACKG_TIMER_SPEEDUP_EN adds SC_BACKG_TIMER_level_In
// and divides each limit by 2^level (floored at 1), latched on reset/clear.
//
// Ports:
//   SC_BACKG_TIMER_CLOCK_50        - system clock
//   SC_BACKG_TIMER_RESET_InHigh    - synchronous reset, active-high
//   SC_BACKG_TIMER_clear_InLow     - synchronous clear of both channels
//   SC_BACKG_TIMER_upcount_InLow   - channel-0 increment strobe
//   SC_BACKG_TIMER_upcount2_InLow  - channel-1 increment strobe
//   SC_BACKG_TIMER_level_In        - speed level (SPEEDUP build only)
//   SC_BACKG_TIMER_T0_OutLow       - channel-0 terminal flag
//   SC_BACKG_TIMER_T1_OutLow       - channel-1 terminal flag
//   SC_BACKG_TIMER_count0_Out/1    - counter values for debug
module sc_backg_timer
    import sc_backg_pkg::*;
#(
    parameter int          DATAWIDTH_TIMER = DATAWIDTH_TIMER_DEF,
    parameter int unsigned T0_LIMIT        = T0_LIMIT_DEF,
    parameter int unsigned T1_LIMIT        = T1_LIMIT_DEF
) (
    input  logic                       SC_BACKG_TIMER_CLOCK_50,
    input  logic                       SC_BACKG_TIMER_RESET_InHigh,
    input  logic                       SC_BACKG_TIMER_clear_InLow,
    input  logic                       SC_BACKG_TIMER_upcount_InLow,
    input  logic                       SC_BACKG_TIMER_upcount2_InLow,
`ifdef SC_BACKG_TIMER_SPEEDUP_EN
    input  logic [1:0]                 SC_BACKG_TIMER_level_In,
`endif
    output logic                       SC_BACKG_TIMER_T0_OutLow,
    output logic                       SC_BACKG_TIMER_T1_OutLow,
    output logic [DATAWIDTH_TIMER-1:0] SC_BACKG_TIMER_count0_Out,
    output logic [DATAWIDTH_TIMER-1:0] SC_BACKG_TIMER_count1_Out
);

    localparam int              W         = DATAWIDTH_TIMER;
    localparam longint unsigned MAX_LIMIT = 64'd1 << DATAWIDTH_TIMER;
    localparam logic [W-1:0]    T0_LIM    = W'(T0_LIMIT);
    localparam logic [W-1:0]    T1_LIM    = W'(T1_LIMIT);

    if (T0_LIMIT == 0 || 64'(T0_LIMIT) >= MAX_LIMIT) begin : g_bad_t0
        $error("sc_backg_timer: T0_LIMIT out of range");
    end
    if (T1_LIMIT == 0 || 64'(T1_LIMIT) >= MAX_LIMIT) begin : g_bad_t1
        $error("sc_backg_timer: T1_LIMIT out of range");
    end

    logic [W-1:0] lim0, lim1;

`ifdef SC_BACKG_TIMER_SPEEDUP_EN
    logic [W-1:0] lim0_q, lim0_d, lim1_q, lim1_d;
    logic [W-1:0] lim0_sh, lim1_sh, lim0_new, lim1_new;

    // The scaled limit is sampled only on reset/clear so a level change
    // mid-round never stretches or cuts the current period.
    always_comb begin
        lim0_sh  = T0_LIM >> SC_BACKG_TIMER_level_In;
        lim1_sh  = T1_LIM >> SC_BACKG_TIMER_level_In;
        lim0_new = (lim0_sh == '0) ? W'(1) : lim0_sh;
        lim1_new = (lim1_sh == '0) ? W'(1) : lim1_sh;
        lim0_d   = SC_BACKG_TIMER_clear_InLow ? lim0_q : lim0_new;
        lim1_d   = SC_BACKG_TIMER_clear_InLow ? lim1_q : lim1_new;
    end

    always_ff @(posedge SC_BACKG_TIMER_CLOCK_50) begin
        if (SC_BACKG_TIMER_RESET_InHigh) begin
            lim0_q <= lim0_new;
            lim1_q <= lim1_new;
        end else begin
            lim0_q <= lim0_d;
            lim1_q <= lim1_d;
        end
    end

    assign lim0 = lim0_q;
    assign lim1 = lim1_q;
`else
    assign lim0 = T0_LIM;
    assign lim1 = T1_LIM;
`endif

    sc_backg_timer_channel #(.W(W)) u_chan0 (
        .clk      (SC_BACKG_TIMER_CLOCK_50),
        .rst      (SC_BACKG_TIMER_RESET_InHigh),
        .clear_n  (SC_BACKG_TIMER_clear_InLow),
        .strobe_n (SC_BACKG_TIMER_upcount_InLow),
        .limit    (lim0),
        .count    (SC_BACKG_TIMER_count0_Out),
        .flag_n   (SC_BACKG_TIMER_T0_OutLow)
    );

    sc_backg_timer_channel #(.W(W)) u_chan1 (
        .clk      (SC_BACKG_TIMER_CLOCK_50),
        .rst      (SC_BACKG_TIMER_RESET_InHigh),
        .clear_n  (SC_BACKG_TIMER_clear_InLow),
        .strobe_n (SC_BACKG_TIMER_upcount2_InLow),
        .limit    (lim1),
        .count    (SC_BACKG_TIMER_count1_Out),
        .flag_n   (SC_BACKG_TIMER_T1_OutLow)
    );

endmodule

// File: tb/tb_sc_backg_timer.sv
// tb/tb_sc_backg_timer.sv - directed self-checking bench for sc_backg_timer
module tb_sc_backg_timer;

    localparam int W = 23;

    logic         clk;
    logic         rst;
    logic         clear_n;
    logic         up_n;
    logic         up2_n;
    logic [1:0]   level;

    logic         t0, t1, t0_b, t1_b;
    logic [W-1:0] c0, c1, c0_b, c1_b;

    int n_checks;
    int n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sc_backg_timer #(.DATAWIDTH_TIMER(W), .T0_LIMIT(4), .T1_LIMIT(6)) u_dut (
        .SC_BACKG_TIMER_CLOCK_50       (clk),
        .SC_BACKG_TIMER_RESET_InHigh   (rst),
        .SC_BACKG_TIMER_clear_InLow    (clear_n),
        .SC_BACKG_TIMER_upcount_InLow  (up_n),
        .SC_BACKG_TIMER_upcount2_InLow (up2_n),
`ifdef SC_BACKG_TIMER_SPEEDUP_EN
        .SC_BACKG_TIMER_level_In       (level),
`endif
        .SC_BACKG_TIMER_T0_OutLow      (t0),
        .SC_BACKG_TIMER_T1_OutLow      (t1),
        .SC_BACKG_TIMER_count0_Out     (c0),
        .SC_BACKG_TIMER_count1_Out     (c1)
    );

    sc_backg_timer #(.DATAWIDTH_TIMER(W), .T0_LIMIT(1), .T1_LIMIT(6)) u_dut_b (
        .SC_BACKG_TIMER_CLOCK_50       (clk),
        .SC_BACKG_TIMER_RESET_InHigh   (rst),
        .SC_BACKG_TIMER_clear_InLow    (clear_n),
        .SC_BACKG_TIMER_upcount_InLow  (up_n),
        .SC_BACKG_TIMER_upcount2_InLow (up2_n),
`ifdef SC_BACKG_TIMER_SPEEDUP_EN
        .SC_BACKG_TIMER_level_In       (level),
`endif
        .SC_BACKG_TIMER_T0_OutLow      (t0_b),
        .SC_BACKG_TIMER_T1_OutLow      (t1_b),
        .SC_BACKG_TIMER_count0_Out     (c0_b),
        .SC_BACKG_TIMER_count1_Out     (c1_b)
    );

`ifdef SC_BACKG_TIMER_SPEEDUP_EN
    logic         t0_s, t1_s;
    logic [W-1:0] c0_s, c1_s;

    sc_backg_timer #(.DATAWIDTH_TIMER(W), .T0_LIMIT(8), .T1_LIMIT(6)) u_dut_s (
        .SC_BACKG_TIMER_CLOCK_50       (clk),
        .SC_BACKG_TIMER_RESET_InHigh   (rst),
        .SC_BACKG_TIMER_clear_InLow    (clear_n),
        .SC_BACKG_TIMER_upcount_InLow  (up_n),
        .SC_BACKG_TIMER_upcount2_InLow (up2_n),
        .SC_BACKG_TIMER_level_In       (level),
        .SC_BACKG_TIMER_T0_OutLow      (t0_s),
        .SC_BACKG_TIMER_T1_OutLow      (t1_s),
        .SC_BACKG_TIMER_count0_Out     (c0_s),
        .SC_BACKG_TIMER_count1_Out     (c1_s)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; up_n = 1'b1; up2_n = 1'b1; clear_n = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse0();
        up_n = 1'b0;
        tick();
        up_n = 1'b1;
    endtask

    task automatic pulse1();
        up2_n = 1'b0;
        tick();
        up2_n = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; up_n = 1'b0; up2_n = 1'b0; clear_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({t0, t1, c0, c1} !== {1'b1, 1'b1, {W{1'b0}}, {W{1'b0}}}) begin
                n_errors++;
                $display("FAIL reset_hold%0d: t0=%b t1=%b c0=%0d c1=%0d, want 1 1 0 0", i, t0, t1, c0, c1);
            end
        end
        rst = 1'b0; up_n = 1'b1; up2_n = 1'b1;
        tick();
        n_checks++;
        if ({t0, t1, c0, c1} !== {1'b1, 1'b1, {W{1'b0}}, {W{1'b0}}}) begin
            n_errors++;
            $display("FAIL reset_release: t0=%b t1=%b c0=%0d c1=%0d, want 1 1 0 0", t0, t1, c0, c1);
        end
    endtask

    task automatic test_period();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            pulse0();
            n_checks++;
            if (c0 !== W'(i) || t0 !== 1'b1) begin
                n_errors++;
                $display("FAIL period_count%0d: c0=%0d t0=%b, want %0d 1", i, c0, t0, i);
            end
            tick();
            tick();
        end
        pulse0();
        n_checks++;
        if (c0 !== '0 || t0 !== 1'b0) begin
            n_errors++;
            $display("FAIL period_terminal: c0=%0d t0=%b, want 0 0", c0, t0);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (t0 !== 1'b0) begin
                n_errors++;
                $display("FAIL period_hold%0d: t0=%b, want 0", i, t0);
            end
        end
        pulse0();
        n_checks++;
        if (c0 !== W'(1) || t0 !== 1'b1) begin
            n_errors++;
            $display("FAIL period_ack: c0=%0d t0=%b, want 1 1", c0, t0);
        end
    endtask

    task automatic test_independence();
        do_reset();
        pulse0();
        pulse0();
        for (int i = 1; i <= 6; i++) begin
            pulse1();
            if (i == 5) begin
                n_checks++;
                if (c1 !== W'(5) || t1 !== 1'b1) begin
                    n_errors++;
                    $display("FAIL indep_pre: c1=%0d t1=%b, want 5 1", c1, t1);
                end
            end
        end
        n_checks++;
        if (c1 !== '0 || t1 !== 1'b0) begin
            n_errors++;
            $display("FAIL indep_t1: c1=%0d t1=%b, want 0 0", c1, t1);
        end
        n_checks++;
        if (c0 !== W'(2) || t0 !== 1'b1) begin
            n_errors++;
            $display("FAIL indep_ch0: c0=%0d t0=%b, want 2 1", c0, t0);
        end
    endtask

    task automatic test_clear();
        do_reset();
        pulse0();
        pulse0();
        pulse0();
        n_checks++;
        if (c0 !== W'(3)) begin
            n_errors++;
            $display("FAIL clear_setup: c0=%0d, want 3", c0);
        end
        clear_n = 1'b0; up_n = 1'b0;
        tick();
        clear_n = 1'b1; up_n = 1'b1;
        n_checks++;
        if (c0 !== '0 || t0 !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_override: c0=%0d t0=%b, want 0 1", c0, t0);
        end
    endtask

    task automatic test_boundary();
        do_reset();
        up_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (t0_b !== 1'b0 || c0_b !== '0) begin
                n_errors++;
                $display("FAIL limit1_strobe%0d: t0=%b c0=%0d, want 0 0", i, t0_b, c0_b);
            end
        end
        up_n = 1'b1;
        tick();
        n_checks++;
        if (t0_b !== 1'b0) begin
            n_errors++;
            $display("FAIL limit1_hold: t0=%b, want 0", t0_b);
        end
        n_checks++;
        if (c0 !== W'(3) || t0 !== 1'b1) begin
            n_errors++;
            $display("FAIL limit4_run3: c0=%0d t0=%b, want 3 1", c0, t0);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        pulse1();
        pulse1();
        up_n = 1'b0; up2_n = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        up_n = 1'b1; up2_n = 1'b1;
        n_checks++;
        if ({t0, t1, c0, c1} !== {1'b0, 1'b0, {W{1'b0}}, {W{1'b0}}}) begin
            n_errors++;
            $display("FAIL both_terminal: t0=%b t1=%b c0=%0d c1=%0d, want 0 0 0 0", t0, t1, c0, c1);
        end
    endtask

    task automatic test_reset_mid();
        // Entered with both channels in TERMINAL.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (t0 !== 1'b1 || t1 !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_terminal: t0=%b t1=%b, want 1 1", t0, t1);
        end
        pulse0();
        n_checks++;
        if (c0 !== W'(1) || t0 !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_restart: c0=%0d t0=%b, want 1 1", c0, t0);
        end
    endtask

`ifdef SC_BACKG_TIMER_SPEEDUP_EN
    task automatic test_speedup();
        level = 2'd2;
        do_reset();
        level = 2'd0;
        pulse0();
        n_checks++;
        if (c0_s !== W'(1) || t0_s !== 1'b1) begin
            n_errors++;
            $display("FAIL speed_first: c0=%0d t0=%b, want 1 1", c0_s, t0_s);
        end
        pulse0();
        n_checks++;
        if (t0_s !== 1'b0 || c0_s !== '0) begin
            n_errors++;
            $display("FAIL speed_lvl2: t0=%b c0=%0d, want 0 0", t0_s, c0_s);
        end
        clear_n = 1'b0;
        tick();
        clear_n = 1'b1;
        for (int i = 1; i <= 7; i++) pulse0();
        n_checks++;
        if (t0_s !== 1'b1 || c0_s !== W'(7)) begin
            n_errors++;
            $display("FAIL speed_lvl0_pre: t0=%b c0=%0d, want 1 7", t0_s, c0_s);
        end
        pulse0();
        n_checks++;
        if (t0_s !== 1'b0) begin
            n_errors++;
            $display("FAIL speed_lvl0: t0=%b, want 0", t0_s);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        level    = 2'd0;
        rst      = 1'b1;
        clear_n  = 1'b1;
        up_n     = 1'b1;
        up2_n    = 1'b1;
        test_reset();
        test_period();
        test_independence();
        test_clear();
        test_boundary();
        test_simultaneous();
        test_reset_mid();
`ifdef SC_BACKG_TIMER_SPEEDUP_EN
        test_speedup();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
